rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter_pkg.sv | 18 +
 rtl/rr_priority_pick.sv | 30 +++
 rtl/rr_mux_arbiter.sv | 104 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter/mux slice.
package rr_mux_arbiter_pkg;

   localparam int unsigned StateW   = 1;
   localparam int unsigned DefNReq  = 4;
   localparam int unsigned DefDataW = 8;

   typedef enum logic [StateW-1:0] {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } state_e;

   // Index width for an N-entry select; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set request at or above ptr_i, wrapping modulo N_REQ.
module rr_priority_pick
   import rr_mux_arbiter_pkg::*;
#(
   parameter  int unsigned N_REQ = DefNReq,
   localparam int unsigned IdxW  = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [IdxW-1:0]  winner_o,
   output logic             any_o
);

   int unsigned idx;

   // Walk from the farthest offset down so the nearest hit to ptr_i is written last.
   always_comb begin
      any_o    = 1'b0;
      winner_o = '0;
      idx      = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr_i) + i) % N_REQ;
         if (req_i[idx]) begin
            any_o    = 1'b1;
            winner_o = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter plus N:1 data mux onto one valid/ready channel.
// Define RR_MUX_ARBITER_HOLD_EN to keep the grant until a beat with in_last is accepted.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter  int unsigned N_REQ  = DefNReq,
   parameter  int unsigned DATA_W = DefDataW,
   localparam int unsigned IdxW   = idx_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        in_valid,
   output logic [N_REQ-1:0]        in_ready,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   input  logic [N_REQ-1:0]        in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [IdxW-1:0]         out_sel,
   output logic                    busy
);

   state_e          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] sel_q, sel_d;
   logic [IdxW-1:0] sel_next;
   logic [IdxW-1:0] winner;
   logic            any_req;
   logic            accept;
   logic            term_accept;

   rr_priority_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req_i    (in_valid),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .any_o    (any_req)
   );

   assign sel_next = (sel_q == IdxW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
   assign accept   = out_valid && out_ready;

`ifdef RR_MUX_ARBITER_HOLD_EN
   assign term_accept = accept && in_last[sel_q];
`else
   logic unused_in_last;
   assign unused_in_last = ^in_last;
   assign term_accept    = accept;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               sel_d   = winner;
               state_d = StGrant;
            end
         end
         StGrant: begin
            // A withdrawn request releases the grant without rotating priority.
            if (!in_valid[sel_q]) begin
               state_d = StIdle;
            end else if (term_accept) begin
               state_d = StIdle;
               ptr_d   = sel_next;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      in_ready  = '0;
      out_data  = '0;
      if (state_q == StGrant) begin
         out_valid       = in_valid[sel_q];
         in_ready[sel_q] = out_ready;
         if (out_valid) begin
            out_data = in_data[sel_q*DATA_W +: DATA_W];
         end
      end
   end

   assign out_sel = sel_q;
   assign busy    = (state_q == StGrant);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N_REQ=4, DATA_W=8): vector table plus scoreboarded sequences.
module tb_rr_mux_arbiter;

   localparam int unsigned NReq  = 4;
   localparam int unsigned DataW = 8;

   logic                   clk;
   logic                   rst;
   logic [NReq-1:0]        in_valid;
   logic [NReq-1:0]        in_ready;
   logic [NReq*DataW-1:0]  in_data;
   logic [NReq-1:0]        in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [DataW-1:0]       out_data;
   logic [1:0]             out_sel;
   logic                   busy;

   rr_mux_arbiter #(
      .N_REQ  (NReq),
      .DATA_W (DataW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  pre;
      logic [3:0]  req;
      logic [31:0] data;
      logic        rdy;
      logic        ev;
      logic [1:0]  es;
      logic [7:0]  ed;
      logic [3:0]  eir;
      logic        eb;
   } vec_t;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] data;
   } exp_t;

   vec_t  vecs[8];
   exp_t  sb_q[$];
   exp_t  e;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    b0;
   logic  r1done;

   localparam logic [31:0] DefData = 32'h4433_2211;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = DefData;
      in_last   = '0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drive_hold_model();
      in_valid[0]    = (b0 < 3);
      in_data[7:0]   = 8'hB0 + 8'(b0);
      in_last[0]     = (b0 == 2);
      in_valid[1]    = !r1done;
      in_data[15:8]  = 8'h22;
      in_last[1]     = 1'b1;
   endtask

   // Pop and check one accepted beat if the channel handshakes this cycle.
   task automatic sb_sample(input string tag);
      if (out_valid && out_ready && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_sel"}, 32'(out_sel), 32'(e.sel));
         chk({tag, "_data"}, 32'(out_data), 32'(e.data));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{4'b0000, 4'b0100, 32'h44A5_2211, 1'b1, 1'b1, 2'd2, 8'hA5, 4'b0100, 1'b1};
      vecs[1] = '{4'b0000, 4'b1111, DefData,       1'b1, 1'b1, 2'd0, 8'h11, 4'b0001, 1'b1};
      vecs[2] = '{4'b0001, 4'b1111, DefData,       1'b1, 1'b1, 2'd1, 8'h22, 4'b0010, 1'b1};
      vecs[3] = '{4'b1000, 4'b1010, DefData,       1'b1, 1'b1, 2'd1, 8'h22, 4'b0010, 1'b1};
      vecs[4] = '{4'b0100, 4'b0011, DefData,       1'b1, 1'b1, 2'd0, 8'h11, 4'b0001, 1'b1};
      vecs[5] = '{4'b0010, 4'b0010, DefData,       1'b0, 1'b1, 2'd1, 8'h22, 4'b0000, 1'b1};
      vecs[6] = '{4'b0000, 4'b1000, DefData,       1'b0, 1'b1, 2'd3, 8'h44, 4'b0000, 1'b1};
      vecs[7] = '{4'b0000, 4'b0000, DefData,       1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0};

      // Reset held two cycles with every requester valid.
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_data   = DefData;
      in_last   = '0;
      out_ready = 1'b1;
      step();
      step();
      smp();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);

      // Table: optional priming grant sets ptr, then one arbitration is observed.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         if (vecs[v].pre != 4'b0000) begin
            in_valid  = vecs[v].pre;
            out_ready = 1'b1;
            step();
            step();
         end
         in_valid  = vecs[v].req;
         in_data   = vecs[v].data;
         out_ready = vecs[v].rdy;
         step();
         smp();
         chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].ev));
         chk($sformatf("vec%0d_out_sel", v), 32'(out_sel), 32'(vecs[v].es));
         chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].ed));
         chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].eir));
         chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].eb));
      end

      // Single requester: after its accept the arbiter idles and ptr moves to 3.
      do_reset();
      in_valid  = 4'b0100;
      in_data   = 32'h44A5_2211;
      out_ready = 1'b1;
      step();
      smp();
      chk("single_out_data", 32'(out_data), 32'hA5);
      step();
      in_valid = 4'b0000;
      smp();
      chk("single_idle_busy", 32'(busy), 32'd0);
      chk("single_idle_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 4'b1111;
      step();
      smp();
      chk("single_ptr_next_sel", 32'(out_sel), 32'd3);

      // Fairness: all valid, ready high; grants must rotate 0,1,2,3,0.
      do_reset();
      in_valid  = 4'b1111;
      in_data   = DefData;
      out_ready = 1'b1;
      sb_q.push_back('{2'd0, 8'h11});
      sb_q.push_back('{2'd1, 8'h22});
      sb_q.push_back('{2'd2, 8'h33});
      sb_q.push_back('{2'd3, 8'h44});
      sb_q.push_back('{2'd0, 8'h11});
      for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
         smp();
         sb_sample("fair");
         step();
      end
      chk("fair_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();

      // Backpressure: grant 1 held with ready low for three cycles.
      do_reset();
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      step();
      for (int c = 0; c < 3; c++) begin
         smp();
         chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_out_data", c), 32'(out_data), 32'h22);
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d_out_sel", c), 32'(out_sel), 32'd1);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'b0010);
      step();
      in_valid = 4'b0000;
      smp();
      chk("bp_after_accept_busy", 32'(busy), 32'd0);

      // Packet hold: requester 0 sends three beats, requester 1 one beat.
      do_reset();
      b0        = 0;
      r1done    = 1'b0;
      out_ready = 1'b1;
      drive_hold_model();
`ifdef RR_MUX_ARBITER_HOLD_EN
      sb_q.push_back('{2'd0, 8'hB0});
      sb_q.push_back('{2'd0, 8'hB1});
      sb_q.push_back('{2'd0, 8'hB2});
      sb_q.push_back('{2'd1, 8'h22});
`else
      sb_q.push_back('{2'd0, 8'hB0});
      sb_q.push_back('{2'd1, 8'h22});
      sb_q.push_back('{2'd0, 8'hB1});
      sb_q.push_back('{2'd0, 8'hB2});
`endif
      for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
         smp();
         if (in_ready[0] && in_valid[0]) b0++;
         if (in_ready[1] && in_valid[1]) r1done = 1'b1;
         sb_sample("hold");
         step();
         drive_hold_model();
      end
      chk("hold_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      in_last = '0;

      // Dropped valid: grant released, ptr (1) unchanged.
      do_reset();
      in_valid  = 4'b0001;
      out_ready = 1'b1;
      step();
      step();
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      step();
      smp();
      chk("drop_granted_sel", 32'(out_sel), 32'd2);
      step();
      in_valid = 4'b0000;
      step();
      smp();
      chk("drop_idle_busy", 32'(busy), 32'd0);
      chk("drop_idle_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 4'b1111;
      step();
      smp();
      chk("drop_ptr_kept_sel", 32'(out_sel), 32'd1);

      // Reset during GRANT: beat not taken, ptr back to 0.
      do_reset();
      in_valid  = 4'b0010;
      out_ready = 1'b1;
      step();
      step();
      in_valid  = 4'b1000;
      out_ready = 1'b0;
      step();
      smp();
      chk("midrst_granted_sel", 32'(out_sel), 32'd3);
      step();
      rst       = 1'b1;
      out_ready = 1'b1;
      step();
      rst       = 1'b0;
      out_ready = 1'b0;
      smp();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_out_sel", 32'(out_sel), 32'd0);
      in_valid = 4'b1111;
      step();
      smp();
      chk("midrst_ptr_zero_sel", 32'(out_sel), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
